// File: rtl/delayed_rf_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// delayed_rf_arbiter_pkg
// Shared types for the delayed register-file read arbiter.
//   reg_addr_t / uint32_t : register address and data word types
//   delayed_rf_req_t      : one lane's operand read request
//   delayed_rf_resp_t     : one lane's captured operand response
//   addr_merge_t          : distinct-address merge result (count + slots)
// ---------------------------------------------------------------------------
package delayed_rf_arbiter_pkg;

  localparam int ISSUE_NUM  = 2;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [31:0]           uint32_t;

  typedef struct packed {
    logic            valid;
    logic [1:0]      rs_use;
    reg_addr_t [1:0] rs;
  } delayed_rf_req_t;

  typedef struct packed {
    logic          valid;
    uint32_t [1:0] data;
  } delayed_rf_resp_t;

  // cnt saturates at 3, meaning "more than two distinct addresses"
  typedef struct packed {
    logic [1:0]      cnt;
    reg_addr_t [1:0] addr;
  } addr_merge_t;

  // An operand needs a port read only if it is used and not x0
  function automatic logic operand_live(input logic use_bit, input reg_addr_t addr);
    return use_bit && (addr != '0);
  endfunction

endpackage

// File: rtl/delayed_rf_rr_pick.sv
// ---------------------------------------------------------------------------
// delayed_rf_rr_pick
// Round-robin one-hot picker: the first set bit of i_elig found when
// scanning upward from i_ptr (wrapping) wins.
//   i_elig   : eligible lanes
//   i_ptr    : lane index where the search starts
//   o_onehot : one-hot winner (all zero when nothing is eligible)
//   o_idx    : index of the winner (0 when nothing is eligible)
// ---------------------------------------------------------------------------
module delayed_rf_rr_pick #(
  parameter int N_LANE = 2,
  parameter int LANE_W = 1
) (
  input  logic [N_LANE-1:0] i_elig,
  input  logic [LANE_W-1:0] i_ptr,
  output logic [N_LANE-1:0] o_onehot,
  output logic [LANE_W-1:0] o_idx
);

  logic              w_found;
  int                w_cand;
  logic [LANE_W-1:0] w_cand_idx;

  // Wrapping scan from the pointer; first eligible lane wins
  always_comb begin
    o_onehot   = '0;
    o_idx      = '0;
    w_found    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int i = 0; i < N_LANE; i++) begin
      w_cand = int'(i_ptr) + i;
      if (w_cand >= N_LANE) begin
        w_cand = w_cand - N_LANE;
      end else begin
        w_cand = w_cand;
      end
      w_cand_idx = w_cand[LANE_W-1:0];
      if (!w_found && i_elig[w_cand_idx]) begin
        w_found              = 1'b1;
        o_onehot[w_cand_idx] = 1'b1;
        o_idx                = w_cand_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/delayed_rf_arbiter.sv
// ---------------------------------------------------------------------------
// delayed_rf_arbiter
// Shares two register-file read ports between N_LANE lanes whose delayed
// instructions need operands. If all eligible lanes together need at most
// two distinct non-zero registers they are all granted; otherwise a single
// round-robin winner is granted. Operands are captured one cycle later and
// kept coherent with write-back until the consumer acks.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_flush, i_stall      : drop everything / hold (no grants, frozen valid)
//   i_req_valid/use/rs    : per-lane request, operand-use mask, rs1/rs2
//   o_req_ready           : combinational grant
//   o_resp_valid/data     : registered per-lane operand response
//   i_resp_ack            : consumer accepts the response
//   o_reg_raddr/i_reg_rdata : shared read ports (data combinational)
//   i_wb_we/waddr/wdata   : write-back buses, highest lane has priority
// ---------------------------------------------------------------------------
module delayed_rf_arbiter
  import delayed_rf_arbiter_pkg::*;
#(
  parameter int N_LANE = ISSUE_NUM
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_flush,
  input  logic                        i_stall,
  input  logic [N_LANE-1:0]           i_req_valid,
  input  logic [N_LANE-1:0][1:0]      i_req_use,
  input  reg_addr_t [N_LANE-1:0][1:0] i_req_rs,
  output logic [N_LANE-1:0]           o_req_ready,
  output logic [N_LANE-1:0]           o_resp_valid,
  output uint32_t [N_LANE-1:0][1:0]   o_resp_data,
  input  logic [N_LANE-1:0]           i_resp_ack,
  output reg_addr_t [1:0]             o_reg_raddr,
  input  uint32_t [1:0]               i_reg_rdata,
  input  logic [N_LANE-1:0]           i_wb_we,
  input  reg_addr_t [N_LANE-1:0]      i_wb_waddr,
  input  uint32_t [N_LANE-1:0]        i_wb_wdata
);

  localparam int LANE_W = (N_LANE > 1) ? $clog2(N_LANE) : 1;

  delayed_rf_req_t [N_LANE-1:0]  w_req;
  logic [N_LANE-1:0]             w_elig;
  logic [N_LANE-1:0]             w_win_oh;
  logic [LANE_W-1:0]             w_win_idx;
  logic [N_LANE-1:0]             w_grant;
  addr_merge_t                   w_all;
  addr_merge_t                   w_win;
  reg_addr_t [1:0]               w_ports;
  logic                          w_single;
  uint32_t [N_LANE-1:0][1:0]     w_cap_data;
  logic [N_LANE-1:0][1:0]        w_hold_hit;
  uint32_t [N_LANE-1:0][1:0]     w_hold_data;
  logic                          w_byp_hit;
  uint32_t                       w_byp_data;

  delayed_rf_resp_t [N_LANE-1:0] r_resp;
  reg_addr_t [N_LANE-1:0][1:0]   r_addr;
  logic [LANE_W-1:0]             r_rr_ptr;

  // Order-preserving merge of live addresses over the masked lanes: slot 0
  // gets the first address met scanning lane0.rs1, lane0.rs2, lane1.rs1 ...
  function automatic addr_merge_t merge_addrs(input logic [N_LANE-1:0] mask,
                                              input delayed_rf_req_t [N_LANE-1:0] reqs);
    addr_merge_t m;
    reg_addr_t   a;
    m = '0;
    for (int l = 0; l < N_LANE; l++) begin
      for (int k = 0; k < 2; k++) begin
        a = reqs[l].rs[k];
        if (mask[l] && operand_live(reqs[l].rs_use[k], a)) begin
          if (m.cnt == 2'd0) begin
            m.addr[0] = a;
            m.cnt     = 2'd1;
          end else if ((m.cnt == 2'd1) && (a != m.addr[0])) begin
            m.addr[1] = a;
            m.cnt     = 2'd2;
          end else if ((m.cnt == 2'd2) && (a != m.addr[0]) && (a != m.addr[1])) begin
            m.cnt = 2'd3;
          end else begin
            m.cnt = m.cnt;
          end
        end else begin
          m.cnt = m.cnt;
        end
      end
    end
    return m;
  endfunction

  // Pack requests and decide eligibility (a lane may re-request in the
  // cycle its previous response is acked)
  always_comb begin
    w_req  = '0;
    w_elig = '0;
    for (int l = 0; l < N_LANE; l++) begin
      w_req[l].valid  = i_req_valid[l];
      w_req[l].rs_use = i_req_use[l];
      w_req[l].rs     = i_req_rs[l];
      w_elig[l] = w_req[l].valid && (!r_resp[l].valid || i_resp_ack[l]) &&
                  !i_stall && !i_flush && !i_rst;
    end
  end

  delayed_rf_rr_pick #(
    .N_LANE (N_LANE),
    .LANE_W (LANE_W)
  ) u_rr_pick (
    .i_elig   (w_elig),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx)
  );

  // Grant selection and read-port address assignment
  always_comb begin
    w_all   = merge_addrs(w_elig, w_req);
    w_win   = merge_addrs(w_win_oh, w_req);
    w_grant = '0;
    w_ports = '0;
    if (w_all.cnt <= 2'd2) begin
      w_grant = w_elig;
      w_ports = w_all.addr;
    end else begin
      w_grant    = w_win_oh;
      w_ports[0] = w_win.addr[0];
      w_ports[1] = (w_win.cnt == 2'd2) ? w_win.addr[1] : '0;
    end
    // A lone grant is always the picker's winner, so its index is w_win_idx
    w_single = ($countones(w_grant) == 1);
  end

  assign o_req_ready = w_grant;
  assign o_reg_raddr = w_ports;

  // Capture values (zero / write-back bypass / port data) and write-back
  // hits against held response addresses; later lanes override earlier ones
  always_comb begin
    w_cap_data  = '0;
    w_hold_hit  = '0;
    w_hold_data = '0;
    w_byp_hit   = 1'b0;
    w_byp_data  = '0;
    for (int l = 0; l < N_LANE; l++) begin
      for (int k = 0; k < 2; k++) begin
        w_byp_hit  = 1'b0;
        w_byp_data = '0;
        for (int j = 0; j < N_LANE; j++) begin
          if (i_wb_we[j] && (i_wb_waddr[j] == w_req[l].rs[k])) begin
            w_byp_hit  = 1'b1;
            w_byp_data = i_wb_wdata[j];
          end else begin
            w_byp_hit = w_byp_hit;
          end
          if (i_wb_we[j] && (r_addr[l][k] != '0) && (i_wb_waddr[j] == r_addr[l][k])) begin
            w_hold_hit[l][k]  = 1'b1;
            w_hold_data[l][k] = i_wb_wdata[j];
          end else begin
            w_hold_hit[l][k] = w_hold_hit[l][k];
          end
        end
        if (!operand_live(w_req[l].rs_use[k], w_req[l].rs[k])) begin
          w_cap_data[l][k] = '0;
        end else if (w_byp_hit) begin
          w_cap_data[l][k] = w_byp_data;
        end else if (w_req[l].rs[k] == w_ports[0]) begin
          w_cap_data[l][k] = i_reg_rdata[0];
        end else begin
          w_cap_data[l][k] = i_reg_rdata[1];
        end
      end
    end
  end

  // Response registers, held-operand coherence and round-robin pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
      for (int l = 0; l < N_LANE; l++) begin
        r_resp[l] <= '0;
        r_addr[l] <= '0;
      end
    end else begin
      for (int l = 0; l < N_LANE; l++) begin
        if (w_grant[l]) begin
          r_resp[l].valid <= 1'b1;
          r_resp[l].data  <= w_cap_data[l];
          for (int k = 0; k < 2; k++) begin
            r_addr[l][k] <= operand_live(w_req[l].rs_use[k], w_req[l].rs[k]) ?
                            w_req[l].rs[k] : '0;
          end
        end else if (i_flush) begin
          r_resp[l].valid <= 1'b0;
        end else if (r_resp[l].valid && (i_stall || !i_resp_ack[l])) begin
          // Held response: keep valid, track write-back to its registers
          for (int k = 0; k < 2; k++) begin
            if (w_hold_hit[l][k]) begin
              r_resp[l].data[k] <= w_hold_data[l][k];
            end else begin
              r_resp[l].data[k] <= r_resp[l].data[k];
            end
          end
        end else begin
          r_resp[l].valid <= 1'b0;
        end
      end
      if (w_single) begin
        r_rr_ptr <= (w_win_idx == LANE_W'(N_LANE - 1)) ? '0 : (w_win_idx + LANE_W'(1));
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  // Registered response outputs
  always_comb begin
    o_resp_valid = '0;
    o_resp_data  = '0;
    for (int l = 0; l < N_LANE; l++) begin
      o_resp_valid[l] = r_resp[l].valid;
      o_resp_data[l]  = r_resp[l].data;
    end
  end

endmodule

// File: tb/tb_delayed_rf_arbiter.sv
// ---------------------------------------------------------------------------
// tb_delayed_rf_arbiter
// Table-driven bench: each row drives one cycle of inputs, checks the
// combinational grant/port addresses before the edge and the registered
// response plus round-robin pointer after it. Reset is checked by hand at
// the start and again at the end with live state.
// ---------------------------------------------------------------------------
module tb_delayed_rf_arbiter;
  import delayed_rf_arbiter_pkg::*;

  localparam int NV = 12;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic                   stall;
  logic [1:0]             req_valid;
  logic [1:0][1:0]        req_use;
  reg_addr_t [1:0][1:0]   req_rs;
  logic [1:0]             req_ready;
  logic [1:0]             resp_valid;
  uint32_t [1:0][1:0]     resp_data;
  logic [1:0]             resp_ack;
  reg_addr_t [1:0]        reg_raddr;
  uint32_t [1:0]          reg_rdata;
  logic [1:0]             wb_we;
  reg_addr_t [1:0]        wb_waddr;
  uint32_t [1:0]          wb_wdata;

  uint32_t rf_mem [32];

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [1:0]           valid;
    logic [1:0][1:0]      use_;
    reg_addr_t [1:0][1:0] rs;
    logic [1:0]           ack;
    logic                 stall;
    logic                 flush;
    logic [1:0]           wb_we;
    reg_addr_t [1:0]      wb_addr;
    uint32_t [1:0]        wb_data;
    logic [1:0]           e_ready;
    reg_addr_t [1:0]      e_raddr;
    logic [1:0]           e_rv;
    uint32_t [1:0][1:0]   e_data;
    logic                 e_rr;
  } vec_t;

  vec_t v [NV];

  delayed_rf_arbiter #(.N_LANE(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .i_stall      (stall),
    .i_req_valid  (req_valid),
    .i_req_use    (req_use),
    .i_req_rs     (req_rs),
    .o_req_ready  (req_ready),
    .o_resp_valid (resp_valid),
    .o_resp_data  (resp_data),
    .i_resp_ack   (resp_ack),
    .o_reg_raddr  (reg_raddr),
    .i_reg_rdata  (reg_rdata),
    .i_wb_we      (wb_we),
    .i_wb_waddr   (wb_waddr),
    .i_wb_wdata   (wb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read
  always_comb begin
    reg_rdata[0] = rf_mem[reg_raddr[0]];
    reg_rdata[1] = rf_mem[reg_raddr[1]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int row, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  function automatic vec_t clear_vec();
    vec_t r;
    r.valid = '0; r.use_ = '0; r.rs = '0; r.ack = '0; r.stall = 1'b0; r.flush = 1'b0;
    r.wb_we = '0; r.wb_addr = '0; r.wb_data = '0;
    r.e_ready = '0; r.e_raddr = '0; r.e_rv = '0; r.e_data = '0; r.e_rr = 1'b0;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [1:0] valid,
                         input logic [1:0] u0, input reg_addr_t a0, input reg_addr_t a1,
                         input logic [1:0] u1, input reg_addr_t b0, input reg_addr_t b1,
                         input logic [1:0] ack);
    v[i] = clear_vec();
    v[i].valid = valid;
    v[i].use_[0] = u0; v[i].rs[0][0] = a0; v[i].rs[0][1] = a1;
    v[i].use_[1] = u1; v[i].rs[1][0] = b0; v[i].rs[1][1] = b1;
    v[i].ack = ack;
  endtask

  task automatic set_wb(input int i, input logic [1:0] we, input reg_addr_t a0, input uint32_t d0,
                        input reg_addr_t a1, input uint32_t d1);
    v[i].wb_we = we;
    v[i].wb_addr[0] = a0; v[i].wb_data[0] = d0;
    v[i].wb_addr[1] = a1; v[i].wb_data[1] = d1;
  endtask

  task automatic set_exp(input int i, input logic [1:0] rdy, input reg_addr_t p0, input reg_addr_t p1,
                         input logic [1:0] rv, input uint32_t d00, input uint32_t d01,
                         input uint32_t d10, input uint32_t d11, input logic rr);
    v[i].e_ready = rdy;
    v[i].e_raddr[0] = p0; v[i].e_raddr[1] = p1;
    v[i].e_rv = rv;
    v[i].e_data[0][0] = d00; v[i].e_data[0][1] = d01;
    v[i].e_data[1][0] = d10; v[i].e_data[1][1] = d11;
    v[i].e_rr = rr;
  endtask

  task automatic drive(input vec_t t);
    req_valid = t.valid; req_use = t.use_; req_rs = t.rs; resp_ack = t.ack;
    stall = t.stall; flush = t.flush;
    wb_we = t.wb_we; wb_waddr = t.wb_addr; wb_wdata = t.wb_data;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'h0 : (32'hA000_0000 + 32'(i));

    // Merge: {3,4} fits two ports, both lanes granted
    set_req(0, 2'b11, 2'b11, 5'd3, 5'd4, 2'b11, 5'd4, 5'd3, 2'b00);
    set_exp(0, 2'b11, 5'd3, 5'd4, 2'b11, 32'hA000_0003, 32'hA000_0004,
            32'hA000_0004, 32'hA000_0003, 1'b0);
    // Conflict: {1,2,5,6} alternates lane0, lane1, lane0 with acks
    set_req(1, 2'b11, 2'b11, 5'd1, 5'd2, 2'b11, 5'd5, 5'd6, 2'b11);
    set_exp(1, 2'b01, 5'd1, 5'd2, 2'b01, 32'hA000_0001, 32'hA000_0002,
            32'hA000_0004, 32'hA000_0003, 1'b1);
    set_req(2, 2'b11, 2'b11, 5'd1, 5'd2, 2'b11, 5'd5, 5'd6, 2'b11);
    set_exp(2, 2'b10, 5'd5, 5'd6, 2'b10, 32'hA000_0001, 32'hA000_0002,
            32'hA000_0005, 32'hA000_0006, 1'b0);
    set_req(3, 2'b11, 2'b11, 5'd1, 5'd2, 2'b11, 5'd5, 5'd6, 2'b11);
    set_exp(3, 2'b01, 5'd1, 5'd2, 2'b01, 32'hA000_0001, 32'hA000_0002,
            32'hA000_0005, 32'hA000_0006, 1'b1);
    // Zero and bypass: rs1=x0, rs2=7 bypassed from wb, lane1 beats lane0
    set_req(4, 2'b01, 2'b11, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 2'b01);
    set_wb(4, 2'b11, 5'd7, 32'h1111_1111, 5'd7, 32'hDEAD_BEEF);
    set_exp(4, 2'b01, 5'd7, 5'd0, 2'b01, 32'h0, 32'hDEAD_BEEF,
            32'hA000_0005, 32'hA000_0006, 1'b1);
    // Held under stall for three cycles; r7 written in the second
    set_req(5, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00);
    v[5].stall = 1'b1;
    set_exp(5, 2'b00, 5'd0, 5'd0, 2'b01, 32'h0, 32'hDEAD_BEEF,
            32'hA000_0005, 32'hA000_0006, 1'b1);
    set_req(6, 2'b01, 2'b11, 5'd1, 5'd2, 2'b00, 5'd0, 5'd0, 2'b00);
    v[6].stall = 1'b1;
    set_wb(6, 2'b01, 5'd7, 32'h1234_5678, 5'd0, 32'h0);
    set_exp(6, 2'b00, 5'd0, 5'd0, 2'b01, 32'h0, 32'h1234_5678,
            32'hA000_0005, 32'hA000_0006, 1'b1);
    // Write to x0 must not touch the held x0 operand
    set_req(7, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00);
    v[7].stall = 1'b1;
    set_wb(7, 2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0);
    set_exp(7, 2'b00, 5'd0, 5'd0, 2'b01, 32'h0, 32'h1234_5678,
            32'hA000_0005, 32'hA000_0006, 1'b1);
    // Lane1 alone: single grant moves pointer 1 -> 0
    set_req(8, 2'b10, 2'b00, 5'd0, 5'd0, 2'b11, 5'd8, 5'd9, 2'b00);
    set_exp(8, 2'b10, 5'd8, 5'd9, 2'b11, 32'h0, 32'h1234_5678,
            32'hA000_0008, 32'hA000_0009, 1'b0);
    // Flush: no grant, both responses dropped, data and pointer kept
    set_req(9, 2'b11, 2'b11, 5'd1, 5'd2, 2'b11, 5'd5, 5'd6, 2'b11);
    v[9].flush = 1'b1;
    set_exp(9, 2'b00, 5'd0, 5'd0, 2'b00, 32'h0, 32'h1234_5678,
            32'hA000_0008, 32'hA000_0009, 1'b0);
    // Unused rs2 captures 0 and leaves port 1 idle
    set_req(10, 2'b01, 2'b01, 5'd10, 5'd11, 2'b00, 5'd0, 5'd0, 2'b00);
    set_exp(10, 2'b01, 5'd10, 5'd0, 2'b01, 32'hA000_000A, 32'h0,
            32'hA000_0008, 32'hA000_0009, 1'b1);
    // Ack with no new request releases the response
    set_req(11, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b01);
    set_exp(11, 2'b00, 5'd0, 5'd0, 2'b00, 32'hA000_000A, 32'h0,
            32'hA000_0008, 32'hA000_0009, 1'b1);

    // Reset with requests present: grants and ports gated off
    rst = 1'b1;
    drive(v[0]);
    @(negedge clk); #1;
    chk("rst_ready", -1, 128'(req_ready), 128'(2'b00));
    chk("rst_raddr", -1, 128'(reg_raddr), 128'(10'd0));
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rvalid", -1, 128'(resp_valid), 128'(2'b00));
    chk("rst_rdata", -1, 128'(resp_data), 128'(0));
    chk("rst_rr", -1, 128'(dut.r_rr_ptr), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    drive(clear_vec());

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      chk("ready", i, 128'(req_ready), 128'(v[i].e_ready));
      chk("raddr", i, 128'(reg_raddr), 128'(v[i].e_raddr));
      @(posedge clk); #1;
      chk("rvalid", i, 128'(resp_valid), 128'(v[i].e_rv));
      chk("rdata", i, 128'(resp_data), 128'(v[i].e_data));
      chk("rr_ptr", i, 128'(dut.r_rr_ptr), 128'(v[i].e_rr));
    end

    // Mid-run reset clears live state
    @(negedge clk);
    rst = 1'b1;
    drive(v[1]);
    #1;
    chk("rst2_ready", NV, 128'(req_ready), 128'(2'b00));
    chk("rst2_raddr", NV, 128'(reg_raddr), 128'(10'd0));
    @(posedge clk); #1;
    chk("rst2_rvalid", NV, 128'(resp_valid), 128'(2'b00));
    chk("rst2_rdata", NV, 128'(resp_data), 128'(0));
    chk("rst2_rr", NV, 128'(dut.r_rr_ptr), 128'(1'b0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/delayed_rf_arbiter.md
# delayed_rf_arbiter

Shares the execute stage's two register-file read ports between the `ISSUE_NUM` issue lanes whose delayed instructions need operand reads. Requests are arbitrated round-robin. Two lanes are granted together when their combined distinct register addresses fit in two ports. Read data is captured into per-lane response registers with one-cycle latency. Captured data is kept coherent with write-back until the response is consumed. The block sits between issue and the delayed register-forward logic in the exec stage.

## Interface
Parameters:
- `N_LANE`, default `ISSUE_NUM` (2): number of requesting lanes.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush; drops all grants and responses.
- `stall`  in  1  downstream hold; no new grants, responses frozen.
- `req_valid`  in  `N_LANE`  lane requests operand read.
- `req_use`  in  `N_LANE`×2  per-lane rs1/rs2 actually needed.
- `req_rs`  in  `N_LANE`×2×`reg_addr_t`  per-lane rs1/rs2 addresses.
- `req_ready`  out  `N_LANE`  grant; combinational in the request cycle.
- `resp_valid`  out  `N_LANE`  operand data valid.
- `resp_data`  out  `N_LANE`×2×32  rs1/rs2 values.
- `resp_ack`  in  `N_LANE`  consumer accepts the response.
- `reg_raddr`  out  2×`reg_addr_t`  shared read-port addresses.
- `reg_rdata`  in  2×32  read-port data, combinational from `reg_raddr`.
- `wb_we`  in  `N_LANE`  write-back enables.
- `wb_waddr`  in  `N_LANE`×`reg_addr_t`  write-back addresses.
- `wb_wdata`  in  `N_LANE`×32  write-back data.

## Operation
- **Eligibility:** a lane is eligible when `req_valid` is set, and either its `resp_valid` is 0 or its `resp_ack` is high this cycle. `stall=0` and `flush=0` are also required.
- **Needed addresses:** the set of used, non-zero `req_rs` values across all eligible lanes, duplicates merged.
  - Set size ≤2: every eligible lane is granted.
  - Otherwise: only the round-robin winner is granted, starting the search at `rr_ptr`.
- **Port assignment:** port 0 takes the lowest-index needed address of the granted lane(s), port 1 the other. An unused port drives 0.
- **`rr_ptr` update:**
  - Single grant: `rr_ptr` ← winner+1 mod `N_LANE`.
  - Multi-grant or no grant: `rr_ptr` unchanged.
- **Capture:** on the grant edge, each granted lane's `resp_data[k]` is loaded with its rs value, then `resp_valid` is set. Value source priority:
  1. `req_rs[k]==0` or `req_use[k]==0` → 0.
  2. Matching `wb_we`/`wb_waddr` → `wb_wdata`; the highest lane index wins.
  3. The port's `reg_rdata`.
- **Held responses:** while `resp_valid` is 1 and not acked, any matching write-back (non-zero address, highest lane wins) overwrites that operand each cycle. This applies during `stall` too.
- **Release:** `resp_ack` with no new grant clears `resp_valid` on the next edge. Ack plus grant in the same cycle loads the new data, and `resp_valid` stays 1.
- **Flush:** clears all `resp_valid` on the next edge. `req_ready` is 0 in the flush cycle. `rr_ptr` and `resp_data` are kept.
- **Reset:** `rr_ptr`=0, `resp_valid`=0, `resp_data`=0. `req_ready` and `reg_raddr` are 0 while `rst` is high.

## Timing
- Latency: request and grant in cycle t; `resp_valid` and `resp_data` in t+1.
- Throughput: one response per lane per cycle with back-to-back acks.
- `req_ready`, `reg_raddr`: combinational from request inputs and `rr_ptr`.
- `resp_*`: registered outputs.
- Reset and flush both take effect at the edge ending the cycle in which they are asserted.
- Starvation bound: a continuously eligible lane is granted within `N_LANE` cycles.

## Structure
- Shared package `cpu_defs`:
  - `delayed_rf_req_t`: valid, use[2], rs[2].
  - `delayed_rf_resp_t`: valid, data[2].
  - Reuse the existing `reg_addr_t` and `uint32_t`.
- One sub-module, `delayed_rf_rr_pick`: round-robin one-hot picker.
  - Inputs: eligible vector, `rr_ptr`.
  - Outputs: one-hot winner, winner index.
- The address-merge logic and capture/bypass registers stay in the top module.

## Test plan
- **Reset:** assert `rst` 2 cycles → `resp_valid`=00, `resp_data`=0, `reg_raddr`=0,0, `rr_ptr`=0.
- **Merge:** lane0 rs=(3,4), lane1 rs=(4,3), both valid → both `req_ready`. `reg_raddr`=(3,4). Next cycle both `resp_valid`, data = RF[3]/RF[4].
- **Conflict:** lane0 (1,2), lane1 (5,6), continuous requests with acks → grants alternate lane0, lane1, lane0. `rr_ptr` toggles 1,0,1.
- **Zero and bypass:** lane0 rs=(0,7), same cycle `wb_we[1]`=1, `wb_waddr[1]`=7, wdata=0xDEADBEEF → response (0, 0xDEADBEEF).
- **Held update:** response held unacked 3 cycles under `stall`; wb writes r7=0x12345678 in cycle 2 → `resp_data[*][1]`=0x12345678, `resp_valid` stays 1.
- **Flush:** flush with both responses valid → `resp_valid`=00 next cycle; no grant that cycle. `rr_ptr` unchanged.
